// File: rtl/flash_pkg.sv
// ---------------------------------------------------------------------------
// flash_pkg -- shared constants and types for the serial flash reader.
//
// Contents:
//   OPC_READ / OPC_FAST_READ : flash read opcodes
//   CMD_BITS .. DATA_BITS    : field lengths of one read frame, in bits
//   flash_state_e            : state encoding of the flash_reader FSM
//
// The FLASH_FAST_READ_EN macro (used by flash_reader) selects which opcode and
// which fields are used; this package always carries both.
// ---------------------------------------------------------------------------
package flash_pkg;

   localparam logic [7:0] OPC_READ      = 8'h03;
   localparam logic [7:0] OPC_FAST_READ = 8'h0B;

   localparam int CMD_BITS   = 8;
   localparam int ADDR_BITS  = 24;
   localparam int DUMMY_BITS = 8;
   localparam int DATA_BITS  = 8;

   // Encoding 3'd7 is never used; DUMMY is only reachable in fast-read builds.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      ADDR  = 3'd2,
      DUMMY = 3'd3,
      DATA  = 3'd4,
      DONE  = 3'd5,
      GAP   = 3'd6
   } flash_state_e;

endpackage

// File: rtl/flash_reader_if.sv
// ---------------------------------------------------------------------------
// flash_reader_if -- consumer-side read request bundle of flash_reader.
//
// Signals:
//   fd_address [23:0] : flash byte address to read
//   fd_valid          : read-request level from the consumer
//   fd_ready          : one-cycle completion pulse from the reader
//   fd [7:0]          : last byte read, held between completions
//
// Handshake: fd_valid is a level, not a pulse. The reader samples it only
// while idle; the cycle it is seen high starts a read and fd_address is
// captured in that same cycle. Later changes to fd_valid or fd_address have no
// effect on the read in flight. Each read ends with exactly one fd_ready cycle
// in which fd already holds the new byte. A request still high when the
// reader returns to idle starts another read.
//
// Modports: master = consumer, slave = flash_reader.
// ---------------------------------------------------------------------------
interface flash_reader_if;

   logic [23:0] fd_address;
   logic        fd_valid;
   logic        fd_ready;
   logic [7:0]  fd;

   modport master (
      output fd_address,
      output fd_valid,
      input  fd_ready,
      input  fd
   );

   modport slave (
      input  fd_address,
      input  fd_valid,
      output fd_ready,
      output fd
   );

endinterface

// File: rtl/flash_sck_gen.sv
// ---------------------------------------------------------------------------
// flash_sck_gen -- SCK phase timer for the flash reader.
//
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   en_i           : run the timer; while low it is held at the start of a
//                    low phase so the first bit always gets a full low phase
//   rise_tick_o    : single-cycle strobe, last cycle of an SCK low phase
//   fall_tick_o    : single-cycle strobe, last cycle of an SCK high phase
//
// Parameter CLK_DIV (1..255): clk cycles per SCK half-period.
// The ticks are enables for the owner's registered SCK, so SCK changes on the
// clk edge that ends the ticking cycle.
// ---------------------------------------------------------------------------
module flash_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic rise_tick_o,
   output logic fall_tick_o
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       high_q, high_d;
   logic       at_last;

   always_comb begin
      at_last = (cnt_q == DIV_LAST);
      cnt_d   = cnt_q;
      high_d  = high_q;
      if (!en_i) begin
         cnt_d  = 8'd0;
         high_d = 1'b0;
      end else if (at_last) begin
         cnt_d  = 8'd0;
         high_d = ~high_q;
      end else begin
         cnt_d  = cnt_q + 8'd1;
      end
   end

   assign rise_tick_o = en_i && at_last && !high_q;
   assign fall_tick_o = en_i && at_last &&  high_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= 8'd0;
         high_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         high_q <= high_d;
      end
   end

endmodule

// File: rtl/flash_reader.sv
// ---------------------------------------------------------------------------
// flash_reader -- single-byte SPI (mode 0) serial flash reader.
//
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   fd_bus       : flash_reader_if.slave (fd_address, fd_valid in;
//                  fd_ready, fd out)
//   spi_sck      : serial clock, idles low
//   spi_cs_n     : chip select, active low
//   spi_mosi     : serial data to the flash
//   spi_miso     : serial data from the flash
//   dbg_state_o  : current FSM state
//
// Parameters:
//   CLK_DIV (1..255) : SCK half-period in clk cycles
//   CS_GAP  (1..255) : spi_cs_n high cycles after a read, DONE cycle included
//
// Build option FLASH_FAST_READ_EN: when defined, uses opcode 8'h0B and sends a
// dummy byte between address and data (48-bit frame); otherwise opcode 8'h03
// and a 40-bit frame, with DUMMY treated as an illegal state.
//
// A frame is opcode, address, [dummy], data, all MSB first. Every output is a
// register, so the bus changes only on clk edges chosen by the FSM.
// ---------------------------------------------------------------------------
module flash_reader
   import flash_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   flash_reader_if.slave       fd_bus,
   output logic                spi_sck,
   output logic                spi_cs_n,
   output logic                spi_mosi,
   input  logic                spi_miso,
   output flash_state_e        dbg_state_o
);

`ifdef FLASH_FAST_READ_EN
   localparam logic [7:0] OPCODE = OPC_FAST_READ;
   localparam int         N_BITS = CMD_BITS + ADDR_BITS + DUMMY_BITS + DATA_BITS;
   localparam logic [5:0] LAST_DUMMY = 6'(CMD_BITS + ADDR_BITS + DUMMY_BITS - 1);
`else
   localparam logic [7:0] OPCODE = OPC_READ;
   localparam int         N_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;
`endif
   localparam logic [5:0] LAST_CMD  = 6'(CMD_BITS - 1);
   localparam logic [5:0] LAST_ADDR = 6'(CMD_BITS + ADDR_BITS - 1);
   localparam logic [5:0] LAST_BIT  = 6'(N_BITS - 1);
   localparam logic [7:0] GAP_LEN   = 8'(CS_GAP);

   flash_state_e state_q;
   logic [5:0]   bit_cnt_q;   // index of the frame bit currently on the bus
   logic [7:0]   gap_cnt_q;   // cs_n-high cycles elapsed, DONE counted as 1
   logic [30:0]  tx_q;        // outgoing bits still to send after the one on MOSI
   logic [7:0]   rx_q;
   logic         sck_q;
   logic         cs_n_q;
   logic         mosi_q;
   logic [7:0]   fd_q;
   logic         fd_ready_q;

   logic         sck_en;
   logic         rise_tick;
   logic         fall_tick;

   // The timer runs only while a frame is on the bus, which also guarantees
   // SCK stays low whenever chip select is high.
`ifdef FLASH_FAST_READ_EN
   assign sck_en = (state_q == CMD) || (state_q == ADDR) ||
                   (state_q == DUMMY) || (state_q == DATA);
`else
   assign sck_en = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
`endif

   flash_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk         (clk),
      .rst         (rst),
      .en_i        (sck_en),
      .rise_tick_o (rise_tick),
      .fall_tick_o (fall_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 6'd0;
         gap_cnt_q  <= 8'd0;
         tx_q       <= '0;
         rx_q       <= 8'h00;
         sck_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         fd_q       <= 8'h00;
         fd_ready_q <= 1'b0;
      end else begin
         fd_ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cs_n_q <= 1'b1;
               sck_q  <= 1'b0;
               mosi_q <= 1'b0;
               if (fd_bus.fd_valid) begin
                  // The address is captured here; tx_q is the only copy used.
                  state_q   <= CMD;
                  cs_n_q    <= 1'b0;
                  mosi_q    <= OPCODE[7];
                  tx_q      <= {OPCODE[6:0], fd_bus.fd_address};
                  bit_cnt_q <= 6'd0;
               end
            end

`ifdef FLASH_FAST_READ_EN
            CMD, ADDR, DUMMY, DATA: begin
`else
            CMD, ADDR, DATA: begin
`endif
               if (rise_tick) begin
                  sck_q <= 1'b1;
                  if (state_q == DATA) begin
                     rx_q <= {rx_q[6:0], spi_miso};
                  end
               end
               if (fall_tick) begin
                  // End of a bit: SCK drops and MOSI moves to the next bit in
                  // the same edge, so MOSI only ever changes with SCK low.
                  sck_q     <= 1'b0;
                  bit_cnt_q <= bit_cnt_q + 6'd1;
                  if (bit_cnt_q < LAST_ADDR) begin
                     mosi_q <= tx_q[30];
                     tx_q   <= {tx_q[29:0], 1'b0};
                  end else begin
                     mosi_q <= 1'b0;
                  end

                  if (bit_cnt_q == LAST_BIT) begin
                     state_q    <= DONE;
                     cs_n_q     <= 1'b1;
                     fd_q       <= rx_q;
                     fd_ready_q <= 1'b1;
                     bit_cnt_q  <= 6'd0;
                  end else if (bit_cnt_q == LAST_CMD) begin
                     state_q <= ADDR;
                  end else if (bit_cnt_q == LAST_ADDR) begin
`ifdef FLASH_FAST_READ_EN
                     state_q <= DUMMY;
                  end else if (bit_cnt_q == LAST_DUMMY) begin
                     state_q <= DATA;
`else
                     state_q <= DATA;
`endif
                  end
               end
            end

            DONE: begin
               cs_n_q <= 1'b1;
               sck_q  <= 1'b0;
               mosi_q <= 1'b0;
               if (GAP_LEN <= 8'd1) begin
                  state_q <= IDLE;
               end else begin
                  state_q   <= GAP;
                  gap_cnt_q <= 8'd2;
               end
            end

            GAP: begin
               cs_n_q <= 1'b1;
               sck_q  <= 1'b0;
               mosi_q <= 1'b0;
               if (gap_cnt_q >= GAP_LEN) begin
                  state_q   <= IDLE;
                  gap_cnt_q <= 8'd0;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 8'd1;
               end
            end

            default: begin
               // Unused encodings (and DUMMY in a plain-read build) recover to
               // idle with the bus released.
               state_q   <= IDLE;
               cs_n_q    <= 1'b1;
               sck_q     <= 1'b0;
               mosi_q    <= 1'b0;
               bit_cnt_q <= 6'd0;
               gap_cnt_q <= 8'd0;
            end
         endcase
      end
   end

   assign spi_sck         = sck_q;
   assign spi_cs_n        = cs_n_q;
   assign spi_mosi        = mosi_q;
   assign fd_bus.fd       = fd_q;
   assign fd_bus.fd_ready = fd_ready_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_flash_reader.sv
// ---------------------------------------------------------------------------
// tb_flash_reader -- self-checking bench for flash_reader.
// A flash model answers on spi_miso; a bus monitor records MOSI frames,
// fd_ready pulses and bus-rule violations. Expected timing and frames come
// from the frame layout: DONE at T + 1 + 2*CLK_DIV*N, repeat period +CS_GAP.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flash_reader;
   import flash_pkg::*;

   localparam int CLK_DIV = 2;
   localparam int CS_GAP  = 4;
`ifdef FLASH_FAST_READ_EN
   localparam int         N_BITS  = 48;
   localparam logic [7:0] EXP_OPC = 8'h0B;
`else
   localparam int         N_BITS  = 40;
   localparam logic [7:0] EXP_OPC = 8'h03;
`endif
   localparam int XFER   = 1 + 2 * CLK_DIV * N_BITS;
   localparam int PERIOD = XFER + CS_GAP;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         spi_sck, spi_cs_n, spi_mosi, spi_miso;
   flash_state_e dbg_state;
   flash_reader_if fd_bus ();

   flash_reader #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk         (clk),
      .rst         (rst),
      .fd_bus      (fd_bus),
      .spi_sck     (spi_sck),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .dbg_state_o (dbg_state)
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- scoreboard ----------------
   logic [7:0]  exp_q[$];
   logic [47:0] frame_q[$];
   int          bits_q[$];
   int          ready_cyc_q[$];
   logic [7:0]  ready_fd_q[$];

   // ---------------- flash model + bus monitor ----------------
   logic [7:0]  cur_resp = 8'h00;
   logic [47:0] mon_frame;
   int          mon_bits, bit_idx;
   int          bus_viol = 0, fd_glitch = 0, frames_seen = 0;
   bit          mon_en = 1'b0;
   logic        prev_sck, prev_cs_n, prev_mosi, prev_rst;
   logic [7:0]  prev_fd;

   task automatic drive_miso();
      if (bit_idx >= N_BITS - 8 && bit_idx < N_BITS)
         spi_miso = cur_resp[3'(7 - (bit_idx - (N_BITS - 8)))];
      else
         spi_miso = 1'($urandom_range(0, 1));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (spi_cs_n === 1'b1 && spi_sck === 1'b1) bus_viol++;
         if (spi_cs_n === 1'b1 && prev_cs_n === 1'b1 && spi_sck !== prev_sck) bus_viol++;
         if (spi_sck === 1'b1 && spi_mosi !== prev_mosi) bus_viol++;
         if (prev_cs_n === 1'b1 && spi_cs_n === 1'b0) begin
            mon_frame = '0; mon_bits = 0; bit_idx = 0;
            drive_miso();
         end
         if (spi_cs_n === 1'b0 && spi_sck === 1'b1 && prev_sck === 1'b0) begin
            mon_frame = {mon_frame[46:0], spi_mosi};
            mon_bits++;
         end
         if (spi_cs_n === 1'b0 && spi_sck === 1'b0 && prev_sck === 1'b1) begin
            bit_idx++;
            drive_miso();
         end
         if (prev_cs_n === 1'b0 && spi_cs_n === 1'b1) begin
            frame_q.push_back(mon_frame);
            bits_q.push_back(mon_bits);
            frames_seen++;
         end
         if (fd_bus.fd_ready === 1'b1) begin
            ready_cyc_q.push_back(cyc);
            ready_fd_q.push_back(fd_bus.fd);
         end
         if (fd_bus.fd !== prev_fd && fd_bus.fd_ready !== 1'b1 && prev_rst !== 1'b1) fd_glitch++;
      end
      prev_sck  = spi_sck;
      prev_cs_n = spi_cs_n;
      prev_mosi = spi_mosi;
      prev_rst  = rst;
      prev_fd   = fd_bus.fd;
   end

   // Reference frame: the byte stream opcode, address, [dummy 00], data slot 00.
   function automatic logic [47:0] exp_frame(input logic [23:0] a);
`ifdef FLASH_FAST_READ_EN
      return {EXP_OPC, a, 8'h00, 8'h00};
`else
      return {8'h00, EXP_OPC, a, 8'h00};
`endif
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_mon();
      frame_q.delete(); bits_q.delete(); ready_cyc_q.delete(); ready_fd_q.delete();
   endtask

   task automatic start_read(input logic [23:0] addr, input logic [7:0] resp, output int t0);
      @(posedge clk); #1;
      cur_resp = resp;
      fd_bus.fd_valid   = 1'b1;
      fd_bus.fd_address = addr;
      t0 = cyc;
      @(posedge clk); #1;
      fd_bus.fd_valid   = 1'b0;
      fd_bus.fd_address = 24'($urandom);
   endtask

   task automatic wait_pulses(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (ready_cyc_q.size() >= n) ok = 1'b1;
      end
      @(negedge clk);
      if (ready_cyc_q.size() >= n) ok = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      fd_bus.fd_valid = 1'b0;
      fd_bus.fd_address = 24'h0;
      spi_miso = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n got %b want 1", spi_cs_n); end
      n_cmp++; if (spi_sck !== 1'b0) begin n_err++; $display("FAIL reset_sck got %b want 0", spi_sck); end
      n_cmp++; if (spi_mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi got %b want 0", spi_mosi); end
      n_cmp++; if (fd_bus.fd_ready !== 1'b0) begin n_err++; $display("FAIL reset_fd_ready got %b want 0", fd_bus.fd_ready); end
      n_cmp++; if (fd_bus.fd !== 8'h00) begin n_err++; $display("FAIL reset_fd got %h want 00", fd_bus.fd); end
      n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL idle_cs_n got %b want 1", spi_cs_n); end
   endtask

   task automatic test_nominal();
      logic [23:0] addrs[4];
      logic [7:0]  resps[4];
      logic [7:0]  exp;
      int t0, cs_hi;
      bit ok;
      addrs[0] = 24'h123456; resps[0] = 8'hA5;
      for (int i = 1; i < 4; i++) begin
         addrs[i] = 24'($urandom);
         resps[i] = 8'($urandom);
      end
      addrs[3] = 24'hFFFFFF;
      for (int i = 0; i < 4; i++) begin
         clear_mon();
         exp_q.push_back(resps[i]);
         start_read(addrs[i], resps[i], t0);
         wait_pulses(1, XFER + 20, ok);
         exp = exp_q.pop_front();
         n_cmp++;
         if (!ok) begin
            n_err++; $display("FAIL nominal_timeout[%0d] got 0 pulses want 1", i);
         end else begin
            n_cmp++; if (ready_cyc_q[0] !== t0 + XFER) begin n_err++; $display("FAIL nominal_ready_cycle[%0d] got T+%0d want T+%0d", i, ready_cyc_q[0] - t0, XFER); end
            n_cmp++; if (ready_fd_q[0] !== exp) begin n_err++; $display("FAIL nominal_fd[%0d] got %h want %h", i, ready_fd_q[0], exp); end
            n_cmp++; if (bits_q.size() != 1 || bits_q[0] != N_BITS || frame_q[0] !== exp_frame(addrs[i])) begin
               n_err++; $display("FAIL nominal_mosi[%0d] got %h (%0d frames) want %h", i, (frame_q.size() > 0) ? frame_q[0] : 48'h0, frame_q.size(), exp_frame(addrs[i]));
            end
         end
         cs_hi = 0;
         repeat (2 * CS_GAP) begin @(negedge clk); if (spi_cs_n === 1'b1) cs_hi++; end
         n_cmp++; if (cs_hi != 2 * CS_GAP || ready_cyc_q.size() != 1) begin
            n_err++; $display("FAIL nominal_gap[%0d] got cs_hi=%0d pulses=%0d want %0d/1", i, cs_hi, ready_cyc_q.size(), 2 * CS_GAP);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] resp;
      int t0, n_exp;
      bit ok;
      clear_mon();
      resp = 8'($urandom_range(1, 255));
      n_exp = 399 / PERIOD + 1;
      for (int k = 0; k < n_exp; k++) exp_q.push_back(resp);
      @(posedge clk); #1;
      cur_resp = resp;
      fd_bus.fd_valid = 1'b1;
      fd_bus.fd_address = 24'h123456;
      t0 = cyc;
      repeat (400) @(posedge clk);
      #1 fd_bus.fd_valid = 1'b0;
      wait_pulses(n_exp, 2 * PERIOD, ok);
      repeat (PERIOD) @(negedge clk);
      n_cmp++; if (ready_cyc_q.size() != n_exp || frame_q.size() != n_exp) begin
         n_err++; $display("FAIL held_count got %0d pulses %0d frames want %0d", ready_cyc_q.size(), frame_q.size(), n_exp);
      end
      for (int k = 0; k < n_exp; k++) begin
         logic [7:0] exp;
         exp = exp_q.pop_front();
         if (k < ready_cyc_q.size()) begin
            n_cmp++; if (ready_cyc_q[k] !== t0 + XFER + k * PERIOD) begin n_err++; $display("FAIL held_cycle[%0d] got T+%0d want T+%0d", k, ready_cyc_q[k] - t0, XFER + k * PERIOD); end
            n_cmp++; if (ready_fd_q[k] !== exp) begin n_err++; $display("FAIL held_fd[%0d] got %h want %h", k, ready_fd_q[k], exp); end
         end
         if (k < frame_q.size()) begin
            n_cmp++; if (frame_q[k] !== exp_frame(24'h123456)) begin n_err++; $display("FAIL held_mosi[%0d] got %h want %h", k, frame_q[k], exp_frame(24'h123456)); end
         end
      end
   endtask

   task automatic test_mid_change();
      logic [7:0] resp;
      int t0;
      bit ok;
      clear_mon();
      resp = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
      cur_resp = resp;
      fd_bus.fd_valid = 1'b1;
      fd_bus.fd_address = 24'h123456;
      t0 = cyc;
      // Hold the request into the middle of the address field, then drop it.
      repeat (1 + 2 * CLK_DIV * 16) @(posedge clk);
      #1;
      fd_bus.fd_valid = 1'b0;
      fd_bus.fd_address = 24'h000000;
      wait_pulses(1, XFER, ok);
      repeat (PERIOD) @(negedge clk);
      n_cmp++; if (ready_cyc_q.size() != 1) begin n_err++; $display("FAIL mid_pulses got %0d want 1", ready_cyc_q.size()); end
      if (ok) begin
         n_cmp++; if (ready_cyc_q[0] !== t0 + XFER) begin n_err++; $display("FAIL mid_cycle got T+%0d want T+%0d", ready_cyc_q[0] - t0, XFER); end
         n_cmp++; if (ready_fd_q[0] !== resp) begin n_err++; $display("FAIL mid_fd got %h want %h", ready_fd_q[0], resp); end
      end
      n_cmp++; if (frame_q.size() != 1 || frame_q[0] !== exp_frame(24'h123456)) begin
         n_err++; $display("FAIL mid_mosi got %h (%0d frames) want %h", (frame_q.size() > 0) ? frame_q[0] : 48'h0, frame_q.size(), exp_frame(24'h123456));
      end
   endtask

   task automatic test_reset_mid_data();
      int t0, c_rst;
      logic [7:0] fd_before;
      start_read(24'($urandom), 8'($urandom_range(1, 255)), t0);
      clear_mon();
      fd_before = fd_bus.fd;
      // High phase of DATA bit 3.
      c_rst = t0 + 1 + 2 * CLK_DIV * (N_BITS - 8 + 3) + CLK_DIV;
      while (cyc < c_rst) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL rstmid_cs_n got %b want 1", spi_cs_n); end
      n_cmp++; if (spi_sck !== 1'b0) begin n_err++; $display("FAIL rstmid_sck got %b want 0", spi_sck); end
      n_cmp++; if (fd_bus.fd !== 8'h00) begin n_err++; $display("FAIL rstmid_fd got %h want 00 (was %h)", fd_bus.fd, fd_before); end
      repeat (PERIOD) @(negedge clk);
      n_cmp++; if (ready_cyc_q.size() != 0 || fd_bus.fd !== 8'h00) begin
         n_err++; $display("FAIL rstmid_no_ready got %0d pulses fd=%h want 0 pulses fd=00", ready_cyc_q.size(), fd_bus.fd);
      end
   endtask

   task automatic test_reset_restart();
      logic [7:0]  resp;
      logic [23:0] addr;
      int t0;
      bit ok;
      clear_mon();
      resp = 8'($urandom_range(1, 255));
      addr = 24'($urandom);
      @(posedge clk); #1;
      rst = 1'b1;
      cur_resp = resp;
      fd_bus.fd_valid = 1'b1;
      fd_bus.fd_address = addr;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL restart_held_cs_n got %b want 1", spi_cs_n); end
      @(posedge clk); #1;
      rst = 1'b0;
      t0 = cyc;
      @(posedge clk); #1;
      fd_bus.fd_valid = 1'b0;
      wait_pulses(1, XFER + 20, ok);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL restart_timeout got 0 pulses want 1");
      end else begin
         n_cmp++; if (ready_cyc_q[0] !== t0 + XFER) begin n_err++; $display("FAIL restart_cycle got T+%0d want T+%0d", ready_cyc_q[0] - t0, XFER); end
         n_cmp++; if (ready_fd_q[0] !== resp) begin n_err++; $display("FAIL restart_fd got %h want %h", ready_fd_q[0], resp); end
      end
      repeat (CS_GAP + 4) @(negedge clk);
   endtask

   task automatic test_bus_rules();
      n_cmp++; if (bus_viol != 0) begin n_err++; $display("FAIL bus_rules got %0d violations want 0", bus_viol); end
      n_cmp++; if (fd_glitch != 0) begin n_err++; $display("FAIL fd_stable got %0d changes want 0", fd_glitch); end
      n_cmp++; if (frames_seen < 10) begin n_err++; $display("FAIL frames_seen got %0d want >= 10", frames_seen); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_nominal();
      test_back_to_back();
      test_mid_change();
      test_reset_mid_data();
      test_reset_restart();
      test_bus_rules();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/flash_reader.md
FLASH_READER -- requirements
Module: flash_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, SCK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter CS_GAP, default 4, minimum spi_cs_n high time in clk cycles between transactions (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port fd_address, input, 24, flash byte address for the read.
REQ-006 SHALL have port fd_valid, input, 1, read-request level from the consumer.
REQ-007 SHALL have port fd_ready, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port fd, output, 8, last byte read.
REQ-009 SHALL have ports spi_sck (output, 1), spi_cs_n (output, 1), spi_mosi (output, 1) and spi_miso (input, 1), forming the serial flash bus.

Function
REQ-010 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, DONE and GAP.
REQ-011 SHALL move from IDLE to CMD, and latch fd_address, on the cycle T in which fd_valid=1 is sampled.
REQ-012 SHALL drive spi_cs_n=0 and spi_mosi=opcode bit 7 from cycle T+1, with spi_sck=0.
REQ-013 SHALL use SPI mode 0:
- each bit is SCK low for CLK_DIV cycles, then high for CLK_DIV cycles;
- MOSI changes only while SCK is low;
- spi_miso is captured on the clk edge that drives SCK high;
- all fields are MSB first.
REQ-014 SHALL transmit the 8-bit opcode (CMD), then the 24-bit latched address (ADDR), then receive 8 data bits (DATA); spi_mosi SHALL be 0 during DATA.
REQ-015 SHALL give the total bit count N as 40 without FLASH_FAST_READ_EN and 48 with it.
REQ-016 SHALL, at cycle T+1+2*CLK_DIV*N, enter DONE and in that cycle:
- drive spi_cs_n=1 and spi_sck=0;
- update fd with the received byte;
- assert fd_ready=1 for exactly that one cycle.
REQ-017 SHALL hold fd stable between completions.
REQ-018 SHALL keep spi_cs_n high for CS_GAP cycles counted from DONE (DONE cycle included), then return to IDLE.
REQ-019 SHALL ignore fd_valid outside IDLE:
- deassertion mid-transaction SHALL NOT abort the transaction;
- fd_address changes mid-transaction SHALL NOT affect the transmitted address.
REQ-020 SHALL start a new transaction if fd_valid is still high in IDLE, so that a held request produces repeated reads, each ending in its own fd_ready pulse.
REQ-021 SHALL keep spi_sck low whenever spi_cs_n=1.
REQ-022 SHALL never produce a partial SCK pulse.
REQ-023 SHALL size the bit counter at 6 bits and the CLK_DIV/CS_GAP counters at 8 bits, with no wrap inside a transaction.
REQ-024 SHALL return any illegal state encoding to IDLE with spi_cs_n=1 on the next cycle.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, fd_ready=0 and fd=8'h00, and clear all counters.
REQ-026 SHALL, when rst is asserted mid-transaction, deassert spi_cs_n on the next clk edge and discard the partial byte (fd=8'h00, no fd_ready).
REQ-027 SHALL start a transaction on the first cycle after rst falls if fd_valid=1.

Configuration
REQ-028 SHALL, with macro FLASH_FAST_READ_EN defined, use opcode 8'h0B and insert one DUMMY byte (8 bits, spi_mosi=0, spi_miso ignored) between ADDR and DATA.
REQ-029 SHALL, with FLASH_FAST_READ_EN undefined, use opcode 8'h03, compile no DUMMY state logic, and treat the DUMMY encoding as illegal.

Structure
REQ-030 SHALL place the opcode constants (READ=8'h03, FAST_READ=8'h0B), the state encoding typedef and the field lengths (8/24/8/8) in shared package flash_pkg.
REQ-031 SHALL instantiate one sub-module, flash_sck_gen, which:
- divides clk by CLK_DIV;
- issues single-cycle rise_tick and fall_tick enables;
- stays idle while its enable input is low.

Verification
REQ-032 SHALL cover nominal read: CLK_DIV=2, fd_address=24'h123456, flash model returns 8'hA5, FLASH_FAST_READ_EN undefined -> MOSI stream 03 12 34 56, fd=8'hA5 and fd_ready=1 at cycle T+161, spi_cs_n=1 for at least 4 cycles afterwards.
REQ-033 SHALL cover fast read: FLASH_FAST_READ_EN defined, CLK_DIV=1, fd_address=24'hFFFFFF, model returns 8'h3C -> MOSI stream 0B FF FF FF 00, fd=8'h3C at cycle T+97.
REQ-034 SHALL cover held request: fd_valid held high for 400 cycles at CLK_DIV=2 -> consecutive fd_ready pulses exactly 165 cycles apart (161+4), each a single cycle.
REQ-035 SHALL cover mid-transaction changes: fd_valid dropped and fd_address changed to 24'h000000 during ADDR -> transmitted address remains 24'h123456, fd_ready still pulses once.
REQ-036 SHALL cover reset mid-DATA: rst=1 during bit 3 of DATA -> spi_cs_n=1 and spi_sck=0 next cycle, fd=8'h00, no fd_ready pulse.
REQ-037 SHALL cover bus checks: spi_sck never toggles while spi_cs_n=1, and spi_mosi never changes while spi_sck=1, across all scenarios above.
